// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_pkg
// Brief    : Shared UART types (character, receive entry) and width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

   // Default character width used by the UART datapath
   localparam int UART_SIZE_DEF = 8;

   typedef logic [UART_SIZE_DEF-1:0] uart_char_t;

   // One buffered character together with its parity-error flag
   typedef struct packed {
      logic       perr;
      uart_char_t data;
   } rx_entry_t;

   // Address width for a power-of-2 array of 'depth' entries
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width able to hold an occupancy count 0..depth inclusive
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage : uart_rx_fifo_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_rts_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rts_ctrl
// Brief    : Hysteresis comparator and registered flow-control output.
//            Output drops at/above HI_WM and rises at/below LO_WM.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rts_ctrl #(
   parameter int LVL_W = 5,
   parameter int HI_WM = 12,
   parameter int LO_WM = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LVL_W-1:0] level_next,
   output logic             rts
);

   localparam logic [LVL_W-1:0] C_HI_LVL = LVL_W'(HI_WM);
   localparam logic [LVL_W-1:0] C_LO_LVL = LVL_W'(LO_WM);

   logic rts_d;
   logic rts_q;

   // Next flow-control state: thresholds act on the upcoming level, else hold
   always_comb begin
      rts_d = rts_q;
      if (level_next >= C_HI_LVL) begin
         rts_d = 1'b0;
      end else if (level_next <= C_LO_LVL) begin
         rts_d = 1'b1;
      end
   end

   // Flow-control register; held low during reset
   always_ff @(posedge clk) begin
      if (reset) begin
         rts_q <= 1'b0;
      end else begin
         rts_q <= rts_d;
      end
   end

   assign rts = rts_q;

endmodule : uart_rts_ctrl
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receive buffer. First-word fall-through FIFO of characters
//            plus parity flags, sticky overflow, and hysteretic RTS output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int UART_SIZE = UART_SIZE_DEF,
   parameter int DEPTH     = 16,
   parameter int RTS_HI_WM = 12,
   parameter int RTS_LO_WM = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [UART_SIZE-1:0]       in_data,
   input  logic                       in_perr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [UART_SIZE-1:0]       out_data,
   output logic                       out_perr,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow,
   input  logic                       clr_ovf,
   output logic                       RTS
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int LVL_W = level_width(DEPTH);
   localparam logic [LVL_W-1:0] C_FULL_LVL = LVL_W'(DEPTH);

   // Same layout as rx_entry_t, sized by this instance's character width
   typedef struct packed {
      logic                 perr;
      logic [UART_SIZE-1:0] data;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q,  level_d;
   logic               overflow_q, overflow_d;
   logic               pop;
   logic               push_ok;
   logic               drop;

   // Handshake decode: a full buffer only takes a push when a pop frees a slot
   always_comb begin
      pop     = (level_q != '0) && out_ready;
      push_ok = in_valid && ((level_q != C_FULL_LVL) || pop);
      drop    = in_valid && !push_ok;
   end

   // Next pointers, occupancy and sticky overflow (a new drop beats the clear)
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   // Control state registers; reset empties the buffer in the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage write; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem_q[wr_ptr_q] <= '{perr: in_perr, data: in_data};
      end
   end

   uart_rts_ctrl #(
      .LVL_W (LVL_W),
      .HI_WM (RTS_HI_WM),
      .LO_WM (RTS_LO_WM)
   ) u_rts_ctrl (
      .clk        (clk),
      .reset      (reset),
      .level_next (level_d),
      .rts        (RTS)
   );

   assign out_valid = (level_q != '0);
   assign out_data  = mem_q[rd_ptr_q].data;
   assign out_perr  = mem_q[rd_ptr_q].perr;
   assign level     = level_q;
   assign overflow  = overflow_q;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int HI_WM = 12;
   localparam int LO_WM = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_perr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_perr;
   logic [4:0] level;
   logic       overflow;
   logic       clr_ovf;
   logic       RTS;

   // Reference model: a queue of {perr,data}, sticky flag and flow-control bit
   logic [8:0] mq [$];
   logic       m_ovf;
   logic       m_rts;

   int n_pass  = 0;
   int n_total = 0;

   uart_rx_fifo #(
      .UART_SIZE (8),
      .DEPTH     (DEPTH),
      .RTS_HI_WM (HI_WM),
      .RTS_LO_WM (LO_WM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_perr   (in_perr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_perr  (out_perr),
      .level     (level),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf),
      .RTS       (RTS)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("level", 32'(level), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("out_data", 32'(out_data), 32'(mq[0][7:0]));
         chk("out_perr", 32'(out_perr), 32'(mq[0][8]));
      end
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("rts", 32'(RTS), 32'(m_rts));
   endtask

   // One clock: apply inputs, advance the model, then compare outputs
   task automatic step(input logic r, input logic iv, input logic [7:0] d,
                       input logic p, input logic rdy, input logic clr);
      logic did_pop;
      logic was_full;
      logic dropped;
      reset     = r;
      in_valid  = iv;
      in_data   = d;
      in_perr   = p;
      out_ready = rdy;
      clr_ovf   = clr;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
         m_rts = 1'b0;
      end else begin
         did_pop  = (mq.size() > 0) && rdy;
         was_full = (mq.size() == DEPTH);
         dropped  = 1'b0;
         if (did_pop) void'(mq.pop_front());
         if (iv) begin
            if (!was_full || did_pop) mq.push_back({p, d});
            else dropped = 1'b1;
         end
         if (dropped) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         if (mq.size() >= HI_WM) m_rts = 1'b0;
         else if (mq.size() <= LO_WM) m_rts = 1'b1;
      end
      #1;
      check_all();
   endtask

   initial begin
      logic [7:0] rd;
      int         pp, pr;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_perr = 1'b0;
      out_ready = 1'b0; clr_ovf = 1'b0;
      mq.delete(); m_ovf = 1'b0; m_rts = 1'b0;

      // Reset then idle
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 8'h00, 0, 0, 0);
         chk("rst_rts", 32'(RTS), 32'd0);
      end
      step(0, 0, 8'h00, 0, 0, 0);
      chk("rts_after_rst", 32'(RTS), 32'd1);
      chk("lvl_after_rst", 32'(level), 32'd0);

      // Two pushes, fall-through, two pops
      step(0, 1, 8'hD9, 0, 0, 0);
      chk("fwft_valid", 32'(out_valid), 32'd1);
      chk("fwft_data", 32'(out_data), 32'hD9);
      step(0, 1, 8'h5A, 1, 0, 0);
      step(0, 0, 8'h00, 0, 0, 0);
      chk("hold_data", 32'(out_data), 32'hD9);
      step(0, 0, 8'h00, 0, 1, 0);
      chk("pop2_data", 32'(out_data), 32'h5A);
      chk("pop2_perr", 32'(out_perr), 32'd1);
      step(0, 0, 8'h00, 0, 1, 0);
      chk("empty_valid", 32'(out_valid), 32'd0);

      // RTS hysteresis on fill and drain
      for (int i = 0; i < 12; i++) begin
         step(0, 1, 8'($urandom), 1'($urandom), 0, 0);
         chk("rts_fill", 32'(RTS), (i + 1 >= HI_WM) ? 32'd0 : 32'd1);
      end
      for (int l = 11; l >= 4; l--) begin
         step(0, 0, 8'h00, 0, 1, 0);
         chk("rts_drain", 32'(RTS), (l <= LO_WM) ? 32'd1 : 32'd0);
      end

      // Overflow on a full buffer, drain order, clear
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0, 0);
      step(0, 1, 8'hAA, 0, 0, 0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_level", 32'(level), 32'd16);
      for (int i = 0; i < 16; i++) begin
         chk("ovf_drain", 32'(out_data), 32'(i));
         step(0, 0, 8'h00, 0, 1, 0);
      end
      step(0, 0, 8'h00, 0, 0, 1);
      chk("ovf_clr", 32'(overflow), 32'd0);

      // Push into a full buffer with a simultaneous pop
      for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom), 1'($urandom), 0, 0);
      step(0, 1, 8'hBB, 0, 1, 0);
      chk("full_pp_ovf", 32'(overflow), 32'd0);
      chk("full_pp_lvl", 32'(level), 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("full_pp_last", 32'(out_data), 32'hBB);
         step(0, 0, 8'h00, 0, 1, 0);
      end

      // Continuous push+pop across pointer wrap, then mid-stream reset
      for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 1'($urandom), 0, 0);
      for (int i = 0; i < 40; i++) begin
         step(0, 1, 8'($urandom), 1'($urandom), 1, 0);
         chk("stream_lvl", 32'(level), 32'd3);
      end
      step(1, 1, 8'h77, 0, 0, 0);
      chk("midrst_lvl", 32'(level), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      step(0, 0, 8'h00, 0, 0, 0);

      // Randomized traffic in phases biased toward full, empty, and balanced
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0: begin pp = 80; pr = 20; end
            1: begin pp = 20; pr = 80; end
            2: begin pp = 60; pr = 60; end
            default: begin pp = 95; pr = 5; end
         endcase
         for (int i = 0; i < 100; i++) begin
            rd = 8'($urandom);
            step(0, 1'($urandom_range(0, 99) < pp), rd, 1'($urandom),
                 1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 99) < 5));
         end
      end

      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_uart_rx_fifo
`default_nettype wire
